// File: rtl/cmos_cap_pkg.sv
// cmos_cap_pkg: shared state encoding, counter widths and default frame geometry for cmos_capture.
package cmos_cap_pkg;
  typedef enum logic [1:0] {WAIT_CFG, SKIP, ARMED, ACTIVE} cap_state_t;
  localparam int ROW_W = 10;
  localparam int PIX_W = 11;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
endpackage

// File: rtl/cmos_sync_edge.sv
// cmos_sync_edge: W-bit 2-flop synchronizer; the low E lanes also get a third flop for rise/fall detection.
module cmos_sync_edge #(
  parameter int W = 11,
  parameter int E = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [E-1:0] o_rise,
  output logic [E-1:0] o_fall
);
  logic [W-1:0] r_s1, r_s2;
  logic [E-1:0] r_s3;
  // two-stage sync for every lane, plus a delayed copy of the edge lanes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2[E-1:0];
    end
  end
  assign o_q    = r_s2;
  assign o_rise = r_s2[E-1:0] & ~r_s3;
  assign o_fall = ~r_s2[E-1:0] & r_s3;
endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: OV7670 byte-pair to RGB565 capture with settling-frame skip; optional line-length check under CMOS_CAPTURE_LINE_CHECK_EN.
module cmos_capture import cmos_cap_pkg::*; #(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FRAME_SKIP = 10
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iCONFIG_DONE,
  input  logic             iCMOS_PCLK,
  input  logic             iCMOS_VSYNC,
  input  logic             iCMOS_HREF,
  input  logic [7:0]       iCMOS_DATA,
  output logic [15:0]      oPIX_DATA,
  output logic             oPIX_VALID,
  output logic             oFRAME_START,
  output logic             oFRAME_DONE,
  output logic [ROW_W-1:0] oROW_CNT,
  output logic             oLINE_ERR
);
  localparam int SK_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP + 1) : 1;
  cap_state_t r_state, w_next;
  logic [10:0] w_q;
  logic [2:0] w_rise, w_fall;
  logic [7:0] w_data;
  logic w_href, w_pclk_rise, w_vs_rise, w_vs_fall, w_href_fall;
  logic w_start, w_active, w_skip_last, w_unused;
  logic [SK_W-1:0] r_skip;
  logic [7:0] r_hi;
  logic r_phase;
  logic [15:0] r_pix;
  logic r_valid, r_fs, r_fd;
  logic [ROW_W-1:0] r_row;

  cmos_sync_edge #(.W(11), .E(3)) u_sync (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_d   ({iCMOS_DATA, iCMOS_HREF, iCMOS_VSYNC, iCMOS_PCLK}),
    .o_q   (w_q),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  assign w_data      = w_q[10:3];
  assign w_href      = w_q[2];
  assign w_pclk_rise = w_rise[0];
  assign w_vs_rise   = w_rise[1];
  assign w_vs_fall   = w_fall[1];
  assign w_href_fall = w_fall[2];
  assign w_unused    = ^{w_q[1:0], w_fall[0], w_rise[2]};
  assign w_start     = iCONFIG_DONE && r_state == ARMED && w_vs_fall;
  assign w_active    = iCONFIG_DONE && r_state == ACTIVE;
  assign w_skip_last = int'(r_skip) + 1 == FRAME_SKIP;

  // state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= WAIT_CFG;
    else r_state <= w_next;
  end

  // next state; losing configuration overrides everything
  always_comb begin
    w_next = r_state;
    if (!iCONFIG_DONE) w_next = WAIT_CFG;
    else if (r_state == WAIT_CFG) w_next = (FRAME_SKIP == 0) ? ARMED : SKIP;
    else if (r_state == SKIP && w_vs_rise && w_skip_last) w_next = ARMED;
    else if (r_state == ARMED && w_vs_fall) w_next = ACTIVE;
    else if (r_state == ACTIVE && w_vs_rise) w_next = ARMED;
  end

  // count settling-frame VSYNC rises; held at zero outside SKIP
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_skip <= '0;
    else if (r_state != SKIP) r_skip <= '0;
    else if (w_vs_rise) r_skip <= r_skip + 1'b1;
  end

  // byte pairing, pixel strobe, frame markers and row counter
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_hi    <= '0;
      r_phase <= 1'b0;
      r_pix   <= '0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      r_row   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      if (w_start) begin
        r_fs    <= 1'b1;
        r_row   <= '0;
        r_phase <= 1'b0;
      end else if (w_active) begin
        if (w_pclk_rise && w_href) begin
          r_phase <= ~r_phase;
          if (!r_phase) r_hi <= w_data;
          else begin
            r_pix   <= {r_hi, w_data};
            r_valid <= 1'b1;
          end
        end
        if (w_href_fall) begin
          r_phase <= 1'b0;
          r_row   <= (r_row == ROW_W'(V_ACTIVE - 1)) ? r_row : r_row + 1'b1;
        end
        r_fd <= w_vs_rise;
      end
    end
  end

  assign oPIX_DATA    = r_pix;
  assign oPIX_VALID   = r_valid;
  assign oFRAME_START = r_fs;
  assign oFRAME_DONE  = r_fd;
  assign oROW_CNT     = r_row;

`ifdef CMOS_CAPTURE_LINE_CHECK_EN
  logic [PIX_W-1:0] r_pix_cnt;
  logic r_line_err;
  // pixels per line; a short or long line latches the error until the next frame start
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pix_cnt  <= '0;
      r_line_err <= 1'b0;
    end else if (w_start) begin
      r_pix_cnt  <= '0;
      r_line_err <= 1'b0;
    end else if (w_active) begin
      if (w_href_fall) begin
        r_pix_cnt <= '0;
        if (r_pix_cnt != PIX_W'(H_ACTIVE)) r_line_err <= 1'b1;
      end else if (w_pclk_rise && w_href && r_phase) r_pix_cnt <= r_pix_cnt + 1'b1;
    end
  end
  assign oLINE_ERR = r_line_err;
`else
  logic w_unused_h;
  assign w_unused_h = H_ACTIVE[0];
  assign oLINE_ERR  = 1'b0;
`endif
endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: randomized camera traffic checked against an event-level capture model.
module tb_cmos_capture;
  localparam int H = 4, V = 3, FS = 2;
  logic iCLK = 0, iRST = 1, iCONFIG_DONE = 0;
  logic iCMOS_PCLK = 0, iCMOS_VSYNC = 0, iCMOS_HREF = 0;
  logic [7:0] iCMOS_DATA = 0;
  logic [15:0] oPIX_DATA;
  logic oPIX_VALID, oFRAME_START, oFRAME_DONE, oLINE_ERR;
  logic [9:0] oROW_CNT;

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(FS)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCONFIG_DONE(iCONFIG_DONE),
    .iCMOS_PCLK(iCMOS_PCLK), .iCMOS_VSYNC(iCMOS_VSYNC), .iCMOS_HREF(iCMOS_HREF),
    .iCMOS_DATA(iCMOS_DATA), .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID),
    .oFRAME_START(oFRAME_START), .oFRAME_DONE(oFRAME_DONE), .oROW_CNT(oROW_CNT),
    .oLINE_ERR(oLINE_ERR)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0, n_fail = 0;
  logic [15:0] obs_q[$], exp_q[$];
  int n_start = 0, n_done = 0;
  bit m_armed = 0, m_cap = 0, e_err = 0;
  int m_rises = 0, e_start = 0, e_done = 0, e_row = 0;

  always @(negedge iCLK) begin
    if (oPIX_VALID) obs_q.push_back(oPIX_DATA);
    if (oFRAME_START) n_start++;
    if (oFRAME_DONE) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic m_restart();
    m_rises = 0;
    m_armed = (FS == 0);
    m_cap   = 0;
  endtask

  task automatic m_vs_rise();
    if (m_cap) begin
      e_done++;
      m_cap   = 0;
      m_armed = 1;
    end else if (!m_armed && iCONFIG_DONE) begin
      m_rises++;
      if (m_rises == FS) m_armed = 1;
    end
  endtask

  task automatic m_vs_fall();
    if (iCONFIG_DONE && m_armed) begin
      m_cap   = 1;
      m_armed = 0;
      e_start++;
      e_row = 0;
      e_err = 0;
    end
  endtask

  task automatic byte_out(input logic [7:0] b);
    iCMOS_DATA = b;
    iCMOS_PCLK = 0;
    repeat (2) @(negedge iCLK);
    iCMOS_PCLK = 1;
    repeat (2) @(negedge iCLK);
  endtask

  task automatic byte_late(input logic [7:0] b);
    iCMOS_DATA = b;
    iCMOS_PCLK = 0;
    repeat (2) @(negedge iCLK);
    iCMOS_PCLK = 1;
    repeat (2) @(posedge iCLK);
    #1 chk("lat_edge2_valid", 32'(oPIX_VALID), 0);
    @(posedge iCLK);
    #1 chk("lat_edge3_valid", 32'(oPIX_VALID), 1);
    chk("lat_edge3_data", 32'(oPIX_DATA), 32'h0000F81F);
    @(negedge iCLK);
  endtask

  task automatic send_bytes(input int n, input bit special);
    logic [7:0] d, hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      if (special && i == 0) d = 8'hF8;
      if (special && i == 1) byte_late(8'h1F);
      else byte_out(d);
      if (special && i == 1) d = 8'h1F;
      if (i % 2 == 0) hi = d;
      else if (m_cap) exp_q.push_back({hi, d});
    end
  endtask

  task automatic line_end(input int nbytes);
    iCMOS_HREF = 0;
    iCMOS_PCLK = 0;
    repeat (4) @(negedge iCLK);
    if (m_cap) begin
      e_row = (e_row < V - 1) ? e_row + 1 : V - 1;
      if (nbytes / 2 != H) e_err = 1;
    end
  endtask

  task automatic send_line(input int nbytes, input bit special);
    iCMOS_HREF = 1;
    send_bytes(nbytes, special);
    line_end(nbytes);
  endtask

  task automatic vsync_pulse();
    iCMOS_VSYNC = 1;
    repeat (8) @(negedge iCLK);
    m_vs_rise();
    iCMOS_VSYNC = 0;
    repeat (8) @(negedge iCLK);
    m_vs_fall();
  endtask

  task automatic check_all(input string tag);
    int bad;
    repeat (2) @(negedge iCLK);
    #1;
    bad = 0;
    if (obs_q.size() == exp_q.size())
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
    chk({tag, "_npix"}, 32'(obs_q.size()), 32'(exp_q.size()));
    chk({tag, "_pixdata"}, 32'(bad), 0);
    chk({tag, "_starts"}, 32'(n_start), 32'(e_start));
    chk({tag, "_dones"}, 32'(n_done), 32'(e_done));
    chk({tag, "_row"}, 32'(oROW_CNT), 32'(e_row));
`ifdef CMOS_CAPTURE_LINE_CHECK_EN
    chk({tag, "_lerr"}, 32'(oLINE_ERR), 32'(e_err));
`else
    chk({tag, "_lerr"}, 32'(oLINE_ERR), 0);
`endif
  endtask

  task automatic frame(input string tag, input int nlines, input int nbytes);
    for (int l = 0; l < nlines; l++) send_line(nbytes, 0);
    check_all({tag, "_lines"});
    vsync_pulse();
    check_all({tag, "_vs"});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(oPIX_DATA), 0);
    chk({tag, "_valid"}, 32'(oPIX_VALID), 0);
    chk({tag, "_fstart"}, 32'(oFRAME_START), 0);
    chk({tag, "_fdone"}, 32'(oFRAME_DONE), 0);
    chk({tag, "_row"}, 32'(oROW_CNT), 0);
    chk({tag, "_lerr"}, 32'(oLINE_ERR), 0);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    #1 chk_zero("reset");
    @(negedge iCLK);
    iRST = 0;
    repeat (3) @(negedge iCLK);
    iCONFIG_DONE = 1;
    m_restart();
    repeat (4) @(negedge iCLK);
    frame("f1", 2, 8);
    frame("f2", 2, 8);
    send_line(8, 1);
    send_line(8, 0);
    check_all("f3_lines");
    vsync_pulse();
    check_all("f3_vs");
    frame("f4", 2, 8);
    send_line(7, 0);
    send_line(8, 0);
    check_all("f5_short_lines");
    vsync_pulse();
    check_all("f5_vs");
    frame("f6_sat", 5, 8);
    iCMOS_HREF = 1;
    send_bytes(4, 0);
    repeat (4) @(negedge iCLK);
    iCONFIG_DONE = 0;
    m_cap = 0;
    m_armed = 0;
    send_bytes(4, 0);
    line_end(8);
    check_all("drop_line");
    vsync_pulse();
    check_all("drop_vs");
    iCONFIG_DONE = 1;
    m_restart();
    repeat (4) @(negedge iCLK);
    frame("f8", 2, 8);
    frame("f9", 2, 8);
    frame("f10", 2, 8);
    iCMOS_HREF = 1;
    send_bytes(3, 0);
    repeat (4) @(negedge iCLK);
    iRST = 1;
    #1 chk_zero("midrst");
    @(negedge iCLK);
    iRST = 0;
    m_restart();
    e_row = 0;
    e_err = 0;
    send_bytes(1, 0);
    line_end(4);
    frame("f11", 2, 8);
    frame("f12", 2, 8);
    frame("f13", 2, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
